// File: rtl/progmem_loadable_if.sv
`default_nettype none
// ============================================================================
//  Module      : progmem_loadable_if
//  Description : Bundle of load-port and fetch-port signals for the loadable
//                program memory.
//                Load port : load_en, ld_valid, ld_data -> ld_ready,
//                            ld_count, ld_overflow
//                Fetch port: fetch_req, fetch_addr -> fetch_valid,
//                            fetch_data, fetch_fault
//                Status    : busy
//                master = loader/CPU side, slave = memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface progmem_loadable_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              load_en;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic [ADDR_W:0]   ld_count;
    logic              ld_overflow;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_fault;
    logic              busy;

    modport master (
        output load_en, ld_valid, ld_data, fetch_req, fetch_addr,
        input  ld_ready, ld_count, ld_overflow,
        input  fetch_valid, fetch_data, fetch_fault, busy
    );

    modport slave (
        input  load_en, ld_valid, ld_data, fetch_req, fetch_addr,
        output ld_ready, ld_count, ld_overflow,
        output fetch_valid, fetch_data, fetch_fault, busy
    );
endinterface
`default_nettype wire

// File: rtl/progmem_loadable.sv
`default_nettype none
// ============================================================================
//  Module      : progmem_loadable
//  Description : DEPTH-word program memory, filled at runtime through a
//                valid/ready word stream and read by the fetch unit through
//                a registered one-cycle port. Out-of-range fetches return
//                NOP (0) with fetch_fault set.
//  Ports       : clk, rst (async, active high)
//                bus (progmem_loadable_if.slave): load port, fetch port, busy
//  Revision    : 1.0 - initial release
// ============================================================================
module progmem_loadable #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    progmem_loadable_if.slave   bus
);
    // Index width into the array; range checks keep the unused upper
    // index values (non power-of-two DEPTH) from ever being used.
    localparam int              c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

    localparam logic [0:0] c_st_run  = 1'b0;
    localparam logic [0:0] c_st_load = 1'b1;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W:0]   r_wp;           // doubles as ld_count
    logic              r_overflow;
    logic              r_fetch_valid;
    logic [DATA_W-1:0] r_fetch_data;
    logic              r_fetch_fault;
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic              w_ld_ready;
    logic              w_wr_en;
    logic              w_ovf_set;
    logic              w_load_entry;
    logic              w_fetch_acc;
    logic              w_fetch_in_range;
    logic [c_idx_w-1:0] w_wr_idx;
    logic [c_idx_w-1:0] w_rd_idx;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_run;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_run:  if (bus.load_en)  w_state_nxt = c_st_load;
            c_st_load: if (!bus.load_en) w_state_nxt = c_st_run;
            default:   w_state_nxt = c_st_run;
        endcase
    end

    // ---------------- state-decoded controls ----------------
    always_comb begin
        w_ld_ready   = 1'b0;
        w_load_entry = 1'b0;
        w_fetch_acc  = 1'b0;
        case (r_state)
            c_st_run: begin
                w_load_entry = bus.load_en;
                // load_en high on a RUN edge means load wins; fetch dropped
                w_fetch_acc  = bus.fetch_req && !bus.load_en;
            end
            c_st_load: begin
                w_ld_ready = (r_wp < c_depth);
            end
            default: ;
        endcase
    end

    assign w_wr_en          = w_ld_ready && bus.ld_valid;
    assign w_ovf_set        = (r_state == c_st_load) && !w_ld_ready && bus.ld_valid;
    assign w_fetch_in_range = ({1'b0, bus.fetch_addr} < c_depth);
    assign w_wr_idx         = r_wp[c_idx_w-1:0];
    assign w_rd_idx         = bus.fetch_addr[c_idx_w-1:0];

    // ---------------- load pointer / overflow flag ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp       <= '0;
            r_overflow <= 1'b0;
        end else if (w_load_entry) begin
            r_wp       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ---------------- storage (not reset; contents survive rst) ----------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= bus.ld_data;
        end
    end

    // ---------------- registered fetch port ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
            r_fetch_fault <= 1'b0;
        end else if (w_fetch_acc) begin
            r_fetch_valid <= 1'b1;
            r_fetch_data  <= w_fetch_in_range ? r_mem[w_rd_idx] : '0;
            r_fetch_fault <= !w_fetch_in_range;
        end else begin
            r_fetch_valid <= 1'b0;
            r_fetch_data  <= '0;
            r_fetch_fault <= 1'b0;
        end
    end

    assign bus.ld_ready    = w_ld_ready;
    assign bus.ld_count    = r_wp;
    assign bus.ld_overflow = r_overflow;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.fetch_data  = r_fetch_data;
    assign bus.fetch_fault = r_fetch_fault;
    assign bus.busy        = (r_state == c_st_load);

endmodule
`default_nettype wire
